ps2_rx_fifo: RTL
================

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2 (min 2): synchroniser flops on ps2_clk and ps2_dat.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8 (power of two, min 2): number of received-byte entries.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000: idle clk cycles allowed between ps2_clk falling edges inside a frame.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port ps2_clk  input  1  asynchronous PS/2 clock pin.
REQ-007 SHALL have port ps2_dat  input  1  asynchronous PS/2 data pin.
REQ-008 SHALL have port rd_en  input  1  pop the head entry when rd_valid=1.
REQ-009 SHALL have port rd_data  output  8  head entry data byte (show-ahead).
REQ-010 SHALL have port rd_par_err  output  1  head entry parity-error flag.
REQ-011 SHALL have port rd_frm_err  output  1  head entry stop-bit (framing) error flag.
REQ-012 SHALL have port rd_valid  output  1  FIFO not empty.
REQ-013 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current number of entries.
REQ-014 SHALL have port overflow  output  1  sticky: a completed frame was dropped because the FIFO was full.
REQ-015 SHALL have port timeout  output  1  one-cycle pulse when a partial frame is aborted.
REQ-016 SHALL have port ovf_clr  input  1  clears overflow.

Function
REQ-017 ps2_clk/ps2_dat SHALL pass through SYNC_STAGES flops (reset value 1); a falling edge SHALL be detected as sync_clk previous=1, current=0, giving a one-cycle sample strobe.
REQ-018 Receiver FSM states SHALL be IDLE, DATA, PARITY, STOP; transitions occur only on a sample strobe or timeout.
REQ-019 IDLE: on strobe with sync_dat=0 SHALL go to DATA and clear bit counter; with sync_dat=1 SHALL stay IDLE (spurious edge ignored).
REQ-020 DATA: each strobe SHALL shift sync_dat into the byte LSB-first; after the 8th bit SHALL go to PARITY.
REQ-021 PARITY: SHALL set par_err = ~(^{data, sync_dat}) (odd parity) and go to STOP.
REQ-022 STOP: SHALL set frm_err = ~sync_dat, push {frm_err, par_err, data} into the FIFO and go to IDLE; frames with errors SHALL still be pushed.
REQ-023 Pushed entry SHALL appear at the FIFO head (rd_valid=1 when previously empty) on the cycle after the stop-bit strobe.
REQ-024 Timeout counter SHALL reset on every strobe and count only outside IDLE; at TIMEOUT_CYCLES SHALL return FSM to IDLE, discard partial data, pulse timeout for one cycle; no push.
REQ-025 rd_en with rd_valid=0 SHALL be ignored; pop SHALL update the head on the next cycle.
REQ-026 Push when full without same-cycle pop SHALL drop the entry and set overflow; FIFO contents unchanged.
REQ-027 Simultaneous push and pop SHALL perform both; when full, no overflow; fifo_count unchanged.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH.
REQ-029 ovf_clr SHALL clear overflow; a drop in the same cycle SHALL win (overflow stays 1).

Reset
REQ-030 On rst_n=0 at a clk edge: FSM=IDLE, bit and timeout counters=0, synchronisers=1, FIFO empty, rd_valid=0, fifo_count=0, overflow=0, timeout=0, rd_data/rd_par_err/rd_frm_err=0.
REQ-031 Reset mid-frame SHALL discard the partial frame; the first frame whose start bit arrives after release SHALL be received correctly.

Structure
REQ-032 Package ps2_pkg SHALL hold the FSM state enum, frame constants (8 data bits, 11-bit frame) and entry bit positions (data [7:0], par_err [8], frm_err [9]).
REQ-033 FIFO storage SHALL be a separate sub-module ps2_rx_fifo_buf (synchronous, show-ahead, parameterised width/depth); FSM, synchroniser and timeout stay in ps2_rx_fifo.

Verification
REQ-034 Frame 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) -> rd_data=0x1C, rd_par_err=0, rd_frm_err=0, fifo_count=1.
REQ-035 Frame 0x1C with parity 1 -> entry 0x1C, rd_par_err=1; with stop 0 -> rd_frm_err=1.
REQ-036 Stop ps2_clk after 4 data bits -> timeout pulse after TIMEOUT_CYCLES, no push; following frame 0xF0 -> rd_data=0xF0 clean.
REQ-037 FIFO_DEPTH=4, frames 0x01..0x05 unread -> fifo_count=4, overflow=1, pops yield 0x01..0x04; ovf_clr -> overflow=0.
REQ-038 Full FIFO, rd_en asserted on the stop-bit push cycle -> fifo_count stays 4, overflow=0, new byte at tail.
REQ-039 rst_n=0 for 1 cycle after 5 data bits -> all outputs reset; next frame 0xAA received with no errors.

Source files
------------

// File: rtl/ps2_rx_fifo_pkg.sv
// ps2_pkg: receiver state encoding, frame constants and FIFO entry layout.
package ps2_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;
   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 11;
   localparam int BIT_CNT_W  = $clog2(DATA_BITS);
   localparam int DATA_LSB   = 0;
   localparam int PAR_BIT    = 8;
   localparam int FRM_BIT    = 9;
   localparam int ENTRY_W    = 10;
endpackage

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: show-ahead read port of the received-byte FIFO.
interface ps2_rx_fifo_if
   import ps2_pkg::*;
#(parameter int DEPTH = 8);
   logic                      rd_en;
   logic [DATA_BITS-1:0]      rd_data;
   logic                      rd_par_err;
   logic                      rd_frm_err;
   logic                      rd_valid;
   logic [$clog2(DEPTH):0]    fifo_count;
   modport slave (input rd_en, output rd_data, rd_par_err, rd_frm_err, rd_valid, fifo_count);
   modport master (output rd_en, input rd_data, rd_par_err, rd_frm_err, rd_valid, fifo_count);
endinterface

// File: rtl/ps2_rx_fifo_buf.sv
// ps2_rx_fifo_buf: synchronous show-ahead FIFO with sticky overflow on dropped pushes.
module ps2_rx_fifo_buf #(
   parameter int W     = 10,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [W-1:0]           wr_data,
   input  logic                   pop,
   input  logic                   ovf_clr,
   output logic [W-1:0]           rd_data,
   output logic                   valid,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;
   assign valid   = count != '0;
   assign do_pop  = pop && valid;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign do_push = push && (count != (AW+1)'(DEPTH) || do_pop);
   assign rd_data = valid ? mem[rd_ptr] : '0;
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= wr_data;
   always_ff @(posedge clk)
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr + AW'(do_push);
         rd_ptr   <= rd_ptr + AW'(do_pop);
         count    <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
         overflow <= (push && !do_push) || (overflow && !ovf_clr);
      end
endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host frame receiver feeding a show-ahead byte FIFO.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ps2_clk,
   input  logic         ps2_dat,
   input  logic         ovf_clr,
   ps2_rx_fifo_if.slave rd,
   output logic         overflow,
   output logic         timeout
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [SYNC_STAGES-1:0] clk_sr, dat_sr;
   logic                   clk_prev, sync_clk, sync_dat, strobe, tmo_hit, push;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   logic [DATA_BITS-1:0]   shreg;
   logic                   par_err;
   logic [TW-1:0]          tcnt;
   logic [ENTRY_W-1:0]     entry, head;
   rx_state_e              state, state_nx;
   assign sync_clk = clk_sr[SYNC_STAGES-1];
   assign sync_dat = dat_sr[SYNC_STAGES-1];
   assign strobe   = clk_prev && !sync_clk;
   assign tmo_hit  = state != IDLE && !strobe && tcnt == TW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk)
      if (!rst_n) begin
         clk_sr   <= '1;
         dat_sr   <= '1;
         clk_prev <= 1'b1;
      end else begin
         clk_sr   <= {clk_sr[SYNC_STAGES-2:0], ps2_clk};
         dat_sr   <= {dat_sr[SYNC_STAGES-2:0], ps2_dat};
         clk_prev <= sync_clk;
      end
   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   always_comb
      state_nx = tmo_hit           ? IDLE :
                 !strobe           ? state :
                 state == IDLE     ? (sync_dat ? IDLE : DATA) :
                 state == DATA     ? (bit_cnt == BIT_CNT_W'(DATA_BITS - 1) ? PARITY : DATA) :
                 state == PARITY   ? STOP : IDLE;
   always_comb begin
      push                            = strobe && state == STOP;
      entry                           = '0;
      entry[DATA_LSB +: DATA_BITS]    = shreg;
      entry[PAR_BIT]                  = par_err;
      entry[FRM_BIT]                  = ~sync_dat;
   end
   // idle time is only counted inside a frame; any strobe restarts the window
   always_ff @(posedge clk)
      if (!rst_n) begin
         bit_cnt <= '0;
         shreg   <= '0;
         par_err <= 1'b0;
         tcnt    <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= tmo_hit;
         tcnt    <= (strobe || state == IDLE || tmo_hit) ? '0 : tcnt + 1'b1;
         if (strobe && state == IDLE) bit_cnt <= '0;
         if (strobe && state == DATA) begin
            shreg   <= {sync_dat, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (strobe && state == PARITY) par_err <= ~(^{shreg, sync_dat});
      end
   ps2_rx_fifo_buf #(.W(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .wr_data  (entry),
      .pop      (rd.rd_en),
      .ovf_clr  (ovf_clr),
      .rd_data  (head),
      .valid    (rd.rd_valid),
      .count    (rd.fifo_count),
      .overflow (overflow)
   );
   assign rd.rd_data    = head[DATA_LSB +: DATA_BITS];
   assign rd.rd_par_err = head[PAR_BIT];
   assign rd.rd_frm_err = head[FRM_BIT];
endmodule
